// File: rtl/vga_sprite_overlay_pkg.sv
// Shared types and constants for the VGA sprite overlay stage.
// Sprite coordinates are in the 320x240 bitmap space.
package vga_overlay_pkg;

    typedef struct packed {
        logic       en;
        logic [8:0] x;
        logic [7:0] y;
        logic [8:0] w;
        logic [7:0] h;
        logic [2:0] color;
    } sprite_t;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;

    // Replicates each bit of a 3-bit {R,G,B} colour onto a 4-bit channel.
    function automatic logic [11:0] expand3to12(input logic [2:0] c);
        return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
    endfunction

endpackage

// File: rtl/vga_sprite_overlay_if.sv
// Video stream in/out plus the sprite configuration write port.
interface vga_sprite_overlay_if;
    logic [3:0] r_in, g_in, b_in;
    logic       hsync_in, vsync_in;
    logic       cfg_wr;
    logic [2:0] cfg_idx;
    logic       cfg_en;
    logic [8:0] cfg_x;
    logic [7:0] cfg_y;
    logic [8:0] cfg_w;
    logic [7:0] cfg_h;
    logic [2:0] cfg_color;
    logic [3:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_hsync, VGA_vsync;

    modport master (
        output r_in, g_in, b_in, hsync_in, vsync_in,
        output cfg_wr, cfg_idx, cfg_en, cfg_x, cfg_y, cfg_w, cfg_h, cfg_color,
        input  VGA_R, VGA_G, VGA_B, VGA_hsync, VGA_vsync
    );

    modport slave (
        input  r_in, g_in, b_in, hsync_in, vsync_in,
        input  cfg_wr, cfg_idx, cfg_en, cfg_x, cfg_y, cfg_w, cfg_h, cfg_color,
        output VGA_R, VGA_G, VGA_B, VGA_hsync, VGA_vsync
    );
endinterface

// File: rtl/vga_sprite_overlay_sprite_hit.sv
// Combinational test of one bitmap pixel against one sprite rectangle.
module sprite_hit
    import vga_overlay_pkg::*;
(
    input  logic [8:0] i_px,
    input  logic [7:0] i_py,
    input  sprite_t    i_sprite,
    output logic       o_hit
);
    logic [9:0] w_x_end;
    logic [9:0] w_y_end;

    // 10-bit sums cannot wrap, so oversized extents simply clip at the screen edge.
    assign w_x_end = {1'b0, i_sprite.x} + {1'b0, i_sprite.w};
    assign w_y_end = {2'b0, i_sprite.y} + {2'b0, i_sprite.h};

    assign o_hit = i_sprite.en
                && (i_px >= i_sprite.x) && ({1'b0, i_px} < w_x_end)
                && (i_py >= i_sprite.y) && ({2'b0, i_py} < w_y_end);
endmodule

// File: rtl/vga_sprite_overlay.sv
// Overlays solid-colour sprites on a 640x480 VGA stream, recovering pixel
// position from sync edges and swapping sprite banks at each vsync edge.
module vga_sprite_overlay
    import vga_overlay_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int H_BACK      = 140,
    parameter int V_BACK      = 32
) (
    input  logic               clk_vga,
    input  logic               reset,
    vga_sprite_overlay_if.slave bus
);
    localparam logic [9:0]  POS_MAX = 10'd1023;
    localparam logic [10:0] H_LO    = 11'(H_BACK);
    localparam logic [10:0] H_HI    = 11'(H_BACK + H_VISIBLE);
    localparam logic [10:0] V_LO    = 11'(V_BACK);
    localparam logic [10:0] V_HI    = 11'(V_BACK + V_VISIBLE);

    logic       r_hs_hist, r_vs_hist, r_locked;
    logic [9:0] r_hpos, r_vpos;
    sprite_t    r_pending [NUM_SPRITES];
    sprite_t    r_active  [NUM_SPRITES];
    logic [11:0] r_rgb;
    logic        r_hs, r_vs;

    logic       w_hfall, w_vfall, w_visible, w_any_hit;
    logic [9:0] w_hpos, w_vpos, w_col, w_row;
    logic [8:0] w_px;
    logic [7:0] w_py;
    logic [2:0] w_color;
    logic [NUM_SPRITES-1:0] w_hit;
    sprite_t    w_wr_sprite;

    assign w_hfall = ~bus.hsync_in & r_hs_hist;
    assign w_vfall = ~bus.vsync_in & r_vs_hist;

    // Position of the pixel currently on the inputs.
    always_comb begin
        w_hpos = (r_hpos == POS_MAX) ? POS_MAX : r_hpos + 10'd1;
        if (w_hfall) w_hpos = '0;
        w_vpos = r_vpos;
        if (w_vfall) w_vpos = '0;
        else if (w_hfall && r_vpos != POS_MAX) w_vpos = r_vpos + 10'd1;
    end

    assign w_visible = ({1'b0, w_hpos} >= H_LO) && ({1'b0, w_hpos} < H_HI)
                    && ({1'b0, w_vpos} >= V_LO) && ({1'b0, w_vpos} < V_HI);
    assign w_col = w_hpos - 10'(H_BACK);
    assign w_row = w_vpos - 10'(V_BACK);
    assign w_px  = 9'(w_col >> 1);
    assign w_py  = 8'(w_row >> 1);

    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_hit
        sprite_hit u_hit (
            .i_px    (w_px),
            .i_py    (w_py),
            .i_sprite(r_active[gi]),
            .o_hit   (w_hit[gi])
        );
    end

    // Descending scan so the lowest-index hitting slot wins.
    always_comb begin
        w_any_hit = 1'b0;
        w_color   = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_any_hit = 1'b1;
                w_color   = r_active[i].color;
            end
        end
    end

    assign w_wr_sprite = '{en: bus.cfg_en, x: bus.cfg_x, y: bus.cfg_y,
                           w: bus.cfg_w, h: bus.cfg_h, color: bus.cfg_color};

    always_ff @(posedge clk_vga) begin
        if (reset) begin
            r_hs_hist <= 1'b1;
            r_vs_hist <= 1'b1;
            r_locked  <= 1'b0;
            r_hpos    <= POS_MAX;
            r_vpos    <= POS_MAX;
        end else begin
            r_hs_hist <= bus.hsync_in;
            r_vs_hist <= bus.vsync_in;
            r_hpos    <= w_hpos;
            r_vpos    <= w_vpos;
            if (w_vfall) r_locked <= 1'b1;
        end
    end

    // The bank copy reads pending before this cycle's write lands.
    always_ff @(posedge clk_vga) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_pending[i] <= '0;
                r_active[i]  <= '0;
            end
        end else begin
            if (w_vfall) r_active <= r_pending;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (bus.cfg_wr && bus.cfg_idx == 3'(i)) r_pending[i] <= w_wr_sprite;
            end
        end
    end

    always_ff @(posedge clk_vga) begin
        if (reset) begin
            r_rgb <= '0;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
        end else begin
            r_hs <= bus.hsync_in;
            r_vs <= bus.vsync_in;
            if (r_locked && w_visible && w_any_hit) r_rgb <= expand3to12(w_color);
            else r_rgb <= {bus.r_in, bus.g_in, bus.b_in};
        end
    end

    assign bus.VGA_R     = r_rgb[11:8];
    assign bus.VGA_G     = r_rgb[7:4];
    assign bus.VGA_B     = r_rgb[3:0];
    assign bus.VGA_hsync = r_hs;
    assign bus.VGA_vsync = r_vs;
endmodule

// File: tb/tb_vga_sprite_overlay.sv
// Bench for vga_sprite_overlay: drives short-frame VGA timing with random
// pixels and sprite writes, comparing every output cycle to a reference model.
module tb_vga_sprite_overlay;
    localparam int NUM_SPRITES = 4;
    localparam int H_BACK      = 16;
    localparam int V_BACK      = 2;
    localparam int LINE        = 660;
    localparam int NL          = 18;
    localparam int HS_LEN      = 8;
    localparam int VS_LINES    = 2;

    logic clk_vga = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_vga = ~clk_vga;

    vga_sprite_overlay_if bus();

    vga_sprite_overlay #(
        .NUM_SPRITES(NUM_SPRITES),
        .H_BACK     (H_BACK),
        .V_BACK     (V_BACK)
    ) dut (
        .clk_vga(clk_vga),
        .reset  (reset),
        .bus    (bus)
    );

    typedef struct {
        bit en;
        int x, y, w, h, color;
    } spr_m_t;

    typedef struct {
        int f, l, c;
        int idx;
        bit en;
        int x, y, w, h, color;
    } wr_t;

    spr_m_t m_pend [NUM_SPRITES];
    spr_m_t m_act  [NUM_SPRITES];
    bit     m_locked = 1'b0;
    wr_t    wq[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, act, exp);
        end
    endtask

    function automatic logic [11:0] colour12(input int c);
        logic [11:0] v;
        v = 12'h000;
        if ((c & 4) != 0) v = v | 12'hF00;
        if ((c & 2) != 0) v = v | 12'h0F0;
        if ((c & 1) != 0) v = v | 12'h00F;
        return v;
    endfunction

    task automatic push_wr(input int f, input int l, input int c, input int idx, input bit en,
                           input int x, input int y, input int w, input int h, input int color);
        wr_t e;
        e.f = f; e.l = l; e.c = c; e.idx = idx; e.en = en;
        e.x = x; e.y = y; e.w = w; e.h = h; e.color = color;
        wq.push_back(e);
    endtask

    task automatic push_random_wr(input int f, input int l);
        push_wr(f, l, $urandom_range(20, 600), $urandom_range(0, 7), 1'($urandom_range(0, 3) != 0),
                $urandom_range(0, 319), $urandom_range(0, 8), $urandom_range(0, 40),
                $urandom_range(0, 6), $urandom_range(0, 7));
    endtask

    // One pixel clock: drive inputs at frame (f) line (l) cycle (c), predict, then check.
    task automatic step_pixel(input int f, input int l, input int c, input bit do_rst);
        logic        hs, vs;
        logic [11:0] rgb, exp_rgb;
        bit          wr, found;
        wr_t         e;
        int          hpos, px, py;
        hs  = (c >= HS_LEN);
        vs  = (l >= VS_LINES);
        rgb = 12'($urandom);
        wr  = 1'b0;
        e   = '{default: 0};
        if (!do_rst && wq.size() > 0 && wq[0].f == f && wq[0].l == l && wq[0].c == c) begin
            e  = wq.pop_front();
            wr = 1'b1;
        end
        reset         = do_rst;
        bus.hsync_in  = hs;
        bus.vsync_in  = vs;
        bus.r_in      = rgb[11:8];
        bus.g_in      = rgb[7:4];
        bus.b_in      = rgb[3:0];
        bus.cfg_wr    = wr;
        bus.cfg_idx   = 3'(e.idx);
        bus.cfg_en    = e.en;
        bus.cfg_x     = 9'(e.x);
        bus.cfg_y     = 8'(e.y);
        bus.cfg_w     = 9'(e.w);
        bus.cfg_h     = 8'(e.h);
        bus.cfg_color = 3'(e.color);

        if (do_rst) begin
            exp_rgb  = 12'h000;
            hs       = 1'b1;
            vs       = 1'b1;
            m_locked = 1'b0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                m_pend[i] = '{default: 0};
                m_act[i]  = '{default: 0};
            end
        end else begin
            if (f >= 0 && l == 0 && c == 0) begin
                m_act    = m_pend;
                m_locked = 1'b1;
            end
            exp_rgb = rgb;
            hpos    = (c > 1023) ? 1023 : c;
            if (m_locked && hpos >= H_BACK && hpos < H_BACK + 640 && l >= V_BACK && l < V_BACK + 480) begin
                px    = (hpos - H_BACK) / 2;
                py    = (l - V_BACK) / 2;
                found = 1'b0;
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    if (!found && m_act[i].en && px >= m_act[i].x && px < m_act[i].x + m_act[i].w
                        && py >= m_act[i].y && py < m_act[i].y + m_act[i].h) begin
                        found   = 1'b1;
                        exp_rgb = colour12(m_act[i].color);
                    end
                end
            end
            if (wr && e.idx < NUM_SPRITES) begin
                m_pend[e.idx] = '{en: e.en, x: e.x, y: e.y, w: e.w, h: e.h, color: e.color};
            end
        end

        @(posedge clk_vga);
        #1;
        check_val("rgb", 32'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 32'(exp_rgb));
        check_val("sync", 32'({bus.VGA_hsync, bus.VGA_vsync}), 32'({hs, vs}));
    endtask

    task automatic run_frame(input int f, input int rst_l, input int rst_c, input int tail);
        for (int l = 0; l < NL; l++) begin
            for (int c = 0; c < LINE + ((l == NL - 1) ? tail : 0); c++) begin
                step_pixel(f, l, c, (l == rst_l) && (c == rst_c));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            m_pend[i] = '{default: 0};
            m_act[i]  = '{default: 0};
        end
        for (int k = 0; k < 3; k++) step_pixel(-1, 2, 100, 1'b1);

        // Unlocked lines with no vsync: pure pass-through.
        for (int l = 2; l < 6; l++) begin
            for (int c = 0; c < LINE; c++) step_pixel(-1, l, c, 1'b0);
        end

        push_wr(0, 5, 100, 0, 1'b1, 10, 5, 4, 2, 3'b100);
        push_wr(0, 6, 50, 1, 1'b1, 10, 5, 4, 2, 3'b010);
        push_wr(0, 7, 10, 7, 1'b1, 0, 0, 300, 200, 3'b111);
        run_frame(0, -1, -1, 0);

        push_wr(1, 0, 0, 2, 1'b1, 318, 0, 10, 9, 3'b001);
        push_wr(1, 0, 5, 3, 1'b1, 0, 0, 0, 9, 3'b111);
        push_wr(1, 9, 300, 0, 1'b1, 50, 5, 4, 2, 3'b100);
        run_frame(1, -1, -1, 0);

        push_wr(2, 9, 200, 0, 1'b0, 50, 5, 4, 2, 3'b100);
        run_frame(2, -1, -1, 0);

        for (int k = 0; k < 5; k++) push_random_wr(3, 2 + 3 * k);
        run_frame(3, -1, -1, 0);

        push_random_wr(4, 2);
        push_random_wr(4, 5);
        push_wr(4, 10, 100, 0, 1'b1, 100, 2, 20, 4, 3'b110);
        push_random_wr(4, 13);
        run_frame(4, 8, 300, 0);

        push_random_wr(5, 3);
        run_frame(5, -1, -1, 800);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
